// File: rtl/window_scan_engine_if.sv
// Bundle of the pixel-read bus, window output stream and scan control
// signals of the window scan engine. The master side is the engine;
// the slave side is the surrounding memory/consumer environment.
interface window_scan_engine_if #(
  parameter int WINDOW_SIZE = 3,
  parameter int PIXEL_WIDTH = 1,
  parameter int ADDR_WIDTH  = 8
);
  // scan control
  logic                                       start;
  logic                                       filterReady;
  logic                                       filterDone;
  // pixel read bus
  logic [ADDR_WIDTH-1:0]                      xAddressOut;
  logic [ADDR_WIDTH-1:0]                      yAddressOut;
  logic                                       readEnable;
  logic [PIXEL_WIDTH-1:0]                     dataIn;
  // window stream
  logic [WINDOW_SIZE*WINDOW_SIZE*PIXEL_WIDTH-1:0] windowData;
  logic [ADDR_WIDTH-1:0]                      xCenterAddress;
  logic [ADDR_WIDTH-1:0]                      yCenterAddress;
  logic                                       windowValid;
  logic                                       windowReady;

  modport master (
    input  start, dataIn, windowReady,
    output filterReady, filterDone, xAddressOut, yAddressOut, readEnable,
           windowData, xCenterAddress, yCenterAddress, windowValid
  );

  modport slave (
    output start, dataIn, windowReady,
    input  filterReady, filterDone, xAddressOut, yAddressOut, readEnable,
           windowData, xCenterAddress, yCenterAddress, windowValid
  );
endinterface

// File: rtl/window_scan_engine.sv
// Window scan engine: walks a WINDOW_SIZE x WINDOW_SIZE window across an
// image in raster order, fetches each window's pixels from a fixed-latency
// memory, and presents the captured window with a valid/ready handshake.
module window_scan_engine #(
  parameter int WINDOW_SIZE  = 3,
  parameter int IMAGE_WIDTH  = 240,
  parameter int IMAGE_HEIGHT = 180,
  parameter int WINDOW_STEP  = 1,
  parameter int PIXEL_WIDTH  = 1,
  parameter int ADDR_WIDTH   = 8,
  parameter int READ_LATENCY = 2
) (
  input logic                   clk,
  input logic                   reset,
  window_scan_engine_if.master  bus
);

  localparam int N     = WINDOW_SIZE * WINDOW_SIZE;
  localparam int IW    = $clog2(WINDOW_SIZE);
  localparam int CW    = $clog2(N);
  localparam int HALF  = (WINDOW_SIZE - 1) / 2;
  localparam int X_MAX = IMAGE_WIDTH - WINDOW_SIZE;
  localparam int Y_MAX = IMAGE_HEIGHT - WINDOW_SIZE;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_OUTPUT,
    S_DONE
  } state_t;

  state_t                  state_reg;
  state_t                  state_next;
  logic [ADDR_WIDTH-1:0]   x_pos_reg;
  logic [ADDR_WIDTH-1:0]   y_pos_reg;
  logic [IW-1:0]           i_reg;
  logic [IW-1:0]           j_reg;
  logic [CW-1:0]           cap_cnt_reg;
  logic [READ_LATENCY-1:0] re_dly_reg;
  logic [N*PIXEL_WIDTH-1:0] window_data;

  logic                    read_en;
  logic                    win_valid;
  logic                    f_ready;
  logic                    f_done;

  // Origin advance: one extra bit so the overflow test cannot wrap.
  logic [ADDR_WIDTH:0]     x_step;
  logic [ADDR_WIDTH:0]     y_step;
  logic                    x_wrap;
  logic                    y_wrap;
  logic                    fetch_last;
  logic                    capture;
  logic                    capture_last;
  logic                    handshake;

  assign x_step       = {1'b0, x_pos_reg} + (ADDR_WIDTH+1)'(WINDOW_STEP);
  assign y_step       = {1'b0, y_pos_reg} + (ADDR_WIDTH+1)'(WINDOW_STEP);
  assign x_wrap       = x_step > (ADDR_WIDTH+1)'(X_MAX);
  assign y_wrap       = y_step > (ADDR_WIDTH+1)'(Y_MAX);
  assign fetch_last   = (i_reg == IW'(WINDOW_SIZE-1)) && (j_reg == IW'(WINDOW_SIZE-1));
  assign capture      = re_dly_reg[READ_LATENCY-1];
  assign capture_last = capture && (cap_cnt_reg == CW'(N-1));
  assign handshake    = (state_reg == S_OUTPUT) && bus.windowReady;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:   if (bus.start) state_next = S_FETCH;
      S_FETCH:  if (fetch_last) state_next = S_WAIT;
      S_WAIT:   if (capture_last) state_next = S_OUTPUT;
      S_OUTPUT: if (bus.windowReady) state_next = (x_wrap && y_wrap) ? S_DONE : S_FETCH;
      S_DONE:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    read_en   = 1'b0;
    win_valid = 1'b0;
    f_ready   = 1'b0;
    f_done    = 1'b0;
    case (state_reg)
      S_IDLE:   f_ready   = 1'b1;
      S_FETCH:  read_en   = 1'b1;
      S_OUTPUT: win_valid = 1'b1;
      S_DONE:   f_done    = 1'b1;
      default:  ;
    endcase
  end

  // Window origin and in-window read counters (j is the column, fastest).
  always_ff @(posedge clk) begin
    if (reset) begin
      x_pos_reg <= '0;
      y_pos_reg <= '0;
      i_reg     <= '0;
      j_reg     <= '0;
    end else begin
      if (state_reg == S_FETCH) begin
        if (j_reg == IW'(WINDOW_SIZE-1)) begin
          j_reg <= '0;
          i_reg <= (i_reg == IW'(WINDOW_SIZE-1)) ? '0 : i_reg + 1'b1;
        end else begin
          j_reg <= j_reg + 1'b1;
        end
      end
      if (handshake) begin
        if (x_wrap) begin
          x_pos_reg <= '0;
          // The last position returns the origin to (0,0) for the next scan.
          y_pos_reg <= y_wrap ? '0 : y_step[ADDR_WIDTH-1:0];
        end else begin
          x_pos_reg <= x_step[ADDR_WIDTH-1:0];
        end
      end
    end
  end

  // Read-valid delay line and capture slot counter; returns still in flight
  // at reset are dropped because the delay line is cleared with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      re_dly_reg  <= '0;
      cap_cnt_reg <= '0;
    end else begin
      re_dly_reg <= READ_LATENCY'({re_dly_reg, read_en});
      if (capture) begin
        cap_cnt_reg <= capture_last ? '0 : cap_cnt_reg + 1'b1;
      end
    end
  end

  // One register per window slot, written when the capture counter hits it.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_slot
      logic [PIXEL_WIDTH-1:0] slot_reg;
      // Store the returning pixel into this slot.
      always_ff @(posedge clk) begin
        if (reset) begin
          slot_reg <= '0;
        end else if (capture && (cap_cnt_reg == CW'(gi))) begin
          slot_reg <= bus.dataIn;
        end
      end
      assign window_data[gi*PIXEL_WIDTH +: PIXEL_WIDTH] = slot_reg;
    end
  endgenerate

  assign bus.xAddressOut    = x_pos_reg + ADDR_WIDTH'(j_reg);
  assign bus.yAddressOut    = y_pos_reg + ADDR_WIDTH'(i_reg);
  assign bus.readEnable     = read_en;
  assign bus.windowData     = window_data;
  assign bus.xCenterAddress = x_pos_reg + ADDR_WIDTH'(HALF);
  assign bus.yCenterAddress = y_pos_reg + ADDR_WIDTH'(HALF);
  assign bus.windowValid    = win_valid;
  assign bus.filterReady    = f_ready;
  assign bus.filterDone     = f_done;

endmodule

// File: doc/window_scan_engine.md
WINDOW_SCAN_ENGINE -- requirements
Module: window_scan_engine

Interface
REQ-001 Parameter WINDOW_SIZE, default 3, window edge length in pixels (odd, >=3).
REQ-002 Parameter IMAGE_WIDTH, default 240, image width in pixels.
REQ-003 Parameter IMAGE_HEIGHT, default 180, image height in pixels.
REQ-004 Parameter WINDOW_STEP, default 1, window displacement between positions in x and y (>=1).
REQ-005 Parameter PIXEL_WIDTH, default 1, bits per pixel.
REQ-006 Parameter ADDR_WIDTH, default 8, width of every x/y address port.
REQ-007 Parameter READ_LATENCY, default 2, cycles from readEnable to valid dataIn (>=1).
REQ-008 clk  input  1  single clock; all logic on rising edge.
REQ-009 reset  input  1  synchronous, active-high reset.
REQ-010 start  input  1  begin one full-image scan; sampled only in IDLE.
REQ-011 xAddressOut, yAddressOut  output  ADDR_WIDTH each  pixel read address.
REQ-012 readEnable  output  1  read request for the address presented this cycle.
REQ-013 dataIn  input  PIXEL_WIDTH  pixel returned READ_LATENCY cycles after its readEnable.
REQ-014 windowData  output  WINDOW_SIZE*WINDOW_SIZE*PIXEL_WIDTH  captured window; slot 0 (top-left) in bits [PIXEL_WIDTH-1:0], raster order, column fastest.
REQ-015 xCenterAddress, yCenterAddress  output  ADDR_WIDTH each  centre pixel of current window.
REQ-016 windowValid  output  1  windowData/centre addresses valid.
REQ-017 windowReady  input  1  downstream accepts window when high with windowValid.
REQ-018 filterReady  output  1  high only in IDLE.
REQ-019 filterDone  output  1  one-cycle pulse after last window accepted.

Function
REQ-020 FSM states IDLE, FETCH, WAIT, OUTPUT, DONE; IDLE->FETCH on start; FETCH->WAIT after N=WINDOW_SIZE^2 reads; WAIT->OUTPUT when N-th pixel captured; OUTPUT->FETCH on handshake if positions remain, else OUTPUT->DONE; DONE->IDLE unconditionally.
REQ-021 Window origin (xPos,yPos) starts (0,0); positions xPos=0,STEP,... while xPos<=IMAGE_WIDTH-WINDOW_SIZE, same rule for y; x fastest.
REQ-022 On handshake, xPos+=STEP; if result exceeds IMAGE_WIDTH-WINDOW_SIZE, xPos=0 and yPos+=STEP; if yPos then exceeds IMAGE_HEIGHT-WINDOW_SIZE, scan ends.
REQ-023 In FETCH, readEnable=1 every cycle, address = (xPos+j, yPos+i), j fastest, i,j in 0..WINDOW_SIZE-1; readEnable=0 in all other states.
REQ-024 readEnable delayed READ_LATENCY cycles through a shift line; each delayed-valid cycle stores dataIn into the next slot of windowData (capture counter 0..N-1).
REQ-025 Latency: start sampled at edge 0 -> readEnable cycles 1..N -> windowValid first high in cycle N+READ_LATENCY+1.
REQ-026 windowValid, windowData and centre addresses held stable while windowValid=1 and windowReady=0.
REQ-027 Next window FETCH begins the cycle after the handshake; windowValid drops that cycle.
REQ-028 Centre address = origin + (WINDOW_SIZE-1)/2 per axis, ADDR_WIDTH arithmetic.
REQ-029 start outside IDLE ignored; start in the DONE cycle ignored.
REQ-030 Total windows per scan = ((IMAGE_WIDTH-WINDOW_SIZE)/STEP+1)*((IMAGE_HEIGHT-WINDOW_SIZE)/STEP+1), integer division.

Reset
REQ-031 Reset forces IDLE, clears origin, i/j and capture counters, delay line and windowData; outputs: addresses 0, readEnable 0, windowValid 0, filterDone 0, filterReady 1.
REQ-032 Reset mid-scan (any state) takes effect next edge; in-flight read returns discarded; no windowValid or filterDone until a new start.

Verification
REQ-033 WS=3, W=5, H=4, STEP=1, L=2, windowReady=1, start pulse -> 6 windows, origins (0,0)(1,0)(2,0)(0,1)(1,1)(2,1), first windowValid cycle 12, one filterDone pulse.
REQ-034 Same config, address check -> first FETCH emits (0,0)(1,0)(2,0)(0,1)(1,1)(2,1)(0,2)(1,2)(2,2); centre (1,1).
REQ-035 windowReady=0 for 5 cycles at first window -> windowValid/windowData constant, readEnable=0, second FETCH starts cycle after windowReady rises.
REQ-036 WS=3, W=7, H=3, STEP=2 -> origins x=0,2,4, y=0 only; 3 windows.
REQ-037 Reset asserted during FETCH of window 2 -> next cycle filterReady=1, readEnable=0; restart yields window 1 at origin (0,0) with correct data.
REQ-038 start pulsed during OUTPUT and DONE -> no effect; exactly one scan, one filterDone.
